serial_subtractor: RTL and testbench

Bit-serial W-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock, through a single full-subtractor cell. It is the subtract-side counterpart of the combinational full adder. It shows the area/latency trade against a ripple array. Operands are accepted with a start/done handshake, and results are held until the next accepted start.

---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/serial_subtractor_full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 130 +++++++++++++
 tb/tb_serial_subtractor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the FSM state encoding and the bit-counter width helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit counter width: $clog2(W), never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin.
// Ports: x_i, y_i, bin_i in; d_o difference, bout_o borrow out.
module full_subtractor (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = x_i ^ y_i ^ bin_i;
    assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor, LSB first, start/done handshake.
// Ports: clk, rst (async high), start, a, b, bin in;
//        busy, done, diff, bout out (all registered).
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           br_q, br_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   res_q, res_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   diff_q, diff_d;
    logic           bout_q, bout_d;

    logic           fs_d;
    logic           fs_b;
    logic [W-1:0]   res_sh;

    full_subtractor u_fs (
        .x_i    (a_q[0]),
        .y_i    (b_q[0]),
        .bin_i  (br_q),
        .d_o    (fs_d),
        .bout_o (fs_b)
    );

    // New bit enters at the MSB; written with shifts so W=1 works.
    assign res_sh = (res_q >> 1) | (W'(fs_d) << (W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = fs_b;
                res_d = res_sh;
                cnt_d = cnt_q + CW'(1);
                // Publish only on the last bit so diff/bout stay frozen.
                if (cnt_q == LAST) begin
                    diff_d  = res_sh;
                    bout_d  = fs_b;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=4 and W=3 instances).
// Compares against an arithmetic model of a - b - bin.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;

    logic       s4, bin4, busy4, done4, bout4;
    logic [3:0] a4, b4, diff4;

    logic       s3, bin3, busy3, done3, bout3;
    logic [2:0] a3, b3, diff3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.W(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (s4),
        .a     (a4),
        .b     (b4),
        .bin   (bin4),
        .busy  (busy4),
        .done  (done4),
        .diff  (diff4),
        .bout  (bout4)
    );

    serial_subtractor #(.W(3)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .start (s3),
        .a     (a3),
        .b     (b3),
        .bin   (bin3),
        .busy  (busy3),
        .done  (done3),
        .diff  (diff3),
        .bout  (bout3)
    );

    // Reference: plain integer subtraction, wrapped to w bits.
    function automatic void model(input int w, input int a, input int b,
                                  input int bi, output int d, output int bo);
        int r;
        r  = a - b - bi;
        d  = r & ((1 << w) - 1);
        bo = (r < 0) ? 1 : 0;
    endfunction

    // Drive one operation on the chosen instance and measure it.
    // Returns in the IDLE cycle after the done pulse.
    task automatic op(input bit sel, input int a, input int b, input int bi,
                      output int lat, output int bcnt,
                      output logic [3:0] d, output logic bo,
                      output bit stable, output bit done_after);
        logic [3:0] d0;
        logic [3:0] av, bv;
        av = a[3:0];
        bv = b[3:0];
        @(negedge clk);
        if (sel) begin
            a3 = av[2:0]; b3 = bv[2:0]; bin3 = bi[0]; s3 = 1'b1;
        end else begin
            a4 = av; b4 = bv; bin4 = bi[0]; s4 = 1'b1;
        end
        d0 = sel ? {1'b0, diff3} : diff4;
        @(posedge clk); #1;
        s4 = 1'b0;
        s3 = 1'b0;
        lat    = 0;
        bcnt   = 0;
        stable = 1'b1;
        while (!(sel ? done3 : done4) && lat < 20) begin
            if (sel ? busy3 : busy4) bcnt++;
            if ((sel ? {1'b0, diff3} : diff4) !== d0) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        d  = sel ? {1'b0, diff3} : diff4;
        bo = sel ? bout3 : bout4;
        @(posedge clk); #1;
        done_after = sel ? done3 : done4;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        s3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
        #12;
        checks++;
        if ({busy4, done4, diff4, bout4} !== 7'd0) begin
            errors++;
            $display("FAIL reset_w4 got busy=%b done=%b diff=%h bout=%b want all 0",
                     busy4, done4, diff4, bout4);
        end
        checks++;
        if ({busy3, done3, diff3, bout3} !== 6'd0) begin
            errors++;
            $display("FAIL reset_w3 got busy=%b done=%b diff=%h bout=%b want all 0",
                     busy3, done3, diff3, bout3);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc, ed, eb;
        logic [3:0] d;
        logic bo;
        bit st, da;
        op(1'b0, 9, 3, 0, lat, bc, d, bo, st, da);
        model(4, 9, 3, 0, ed, eb);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL latency_9m3 got %0d want 4", lat);
        end
        checks++;
        if (bc !== 4) begin
            errors++; $display("FAIL busy_cycles got %0d want 4", bc);
        end
        checks++;
        if (d !== 4'(ed) || bo !== 1'(eb)) begin
            errors++;
            $display("FAIL diff_9m3 got %0d/%b want %0d/%0d", d, bo, ed, eb);
        end
        checks++;
        if (da !== 1'b0) begin
            errors++; $display("FAIL done_width got done=%b after pulse want 0", da);
        end
        op(1'b0, 3, 9, 0, lat, bc, d, bo, st, da);
        model(4, 3, 9, 0, ed, eb);
        checks++;
        if (d !== 4'(ed) || bo !== 1'(eb)) begin
            errors++;
            $display("FAIL diff_3m9 got %0d/%b want %0d/%0d", d, bo, ed, eb);
        end
    endtask

    task automatic test_boundary();
        int lat, bc;
        logic [3:0] d;
        logic bo;
        bit st, da;
        op(1'b0, 0, 0, 1, lat, bc, d, bo, st, da);
        checks++;
        if (d !== 4'hF || bo !== 1'b1) begin
            errors++; $display("FAIL diff_0m0b1 got %h/%b want f/1", d, bo);
        end
        op(1'b0, 15, 15, 0, lat, bc, d, bo, st, da);
        checks++;
        if (d !== 4'h0 || bo !== 1'b0) begin
            errors++; $display("FAIL diff_fmf got %h/%b want 0/0", d, bo);
        end
        checks++;
        if (st !== 1'b1) begin
            errors++; $display("FAIL hold_prior got stable=%b want 1", st);
        end
    endtask

    task automatic test_ignore_start();
        int nd;
        logic [3:0] dv;
        logic bv;
        @(negedge clk);
        a4 = 4'd7; b4 = 4'd2; bin4 = 1'b0; s4 = 1'b1;
        @(posedge clk); #1;
        s4 = 1'b0;
        @(posedge clk); #1;
        s4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
        @(posedge clk); #1;
        s4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
        nd = 0; dv = '0; bv = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (done4) begin
                nd++;
                dv = diff4;
                bv = bout4;
                // Request during DONE must also be dropped.
                if (nd == 1) s4 = 1'b1;
            end else begin
                s4 = 1'b0;
            end
            @(posedge clk); #1;
        end
        s4 = 1'b0;
        checks++;
        if (nd !== 1) begin
            errors++; $display("FAIL ignore_done_count got %0d want 1", nd);
        end
        checks++;
        if (dv !== 4'd5 || bv !== 1'b0) begin
            errors++; $display("FAIL ignore_diff got %0d/%b want 5/0", dv, bv);
        end
    endtask

    task automatic test_reset_mid();
        int nd, lat, bc;
        logic [3:0] d;
        logic bo;
        bit st, da;
        @(negedge clk);
        a4 = 4'd12; b4 = 4'd5; bin4 = 1'b0; s4 = 1'b1;
        @(posedge clk); #1;
        s4 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy4, done4, diff4, bout4} !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b done=%b diff=%h bout=%b want all 0",
                     busy4, done4, diff4, bout4);
        end
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done4 || busy4) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++; $display("FAIL reset_no_done got %0d active cycles want 0", nd);
        end
        op(1'b0, 12, 5, 0, lat, bc, d, bo, st, da);
        checks++;
        if (d !== 4'd7 || bo !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL after_reset got %0d/%b lat %0d want 7/0 lat 4", d, bo, lat);
        end
    endtask

    task automatic test_random();
        int lat, bc, ed, eb, ra, rb, rbi;
        logic [3:0] d;
        logic bo;
        bit st, da;
        for (int i = 0; i < 30; i++) begin
            ra  = int'($urandom_range(0, 15));
            rb  = int'($urandom_range(0, 15));
            rbi = int'($urandom_range(0, 1));
            op(1'b0, ra, rb, rbi, lat, bc, d, bo, st, da);
            model(4, ra, rb, rbi, ed, eb);
            checks++;
            if (d !== 4'(ed) || bo !== 1'(eb) || lat !== 4 || st !== 1'b1) begin
                errors++;
                $display("FAIL rand_w4 %0d-%0d-%0d got %0d/%b lat %0d st %b want %0d/%0d lat 4 st 1",
                         ra, rb, rbi, d, bo, lat, st, ed, eb);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, ed, eb;
        logic [3:0] d;
        logic bo;
        bit st, da;
        for (int ra = 0; ra < 8; ra++) begin
            for (int rb = 0; rb < 8; rb++) begin
                for (int rbi = 0; rbi < 2; rbi++) begin
                    op(1'b1, ra, rb, rbi, lat, bc, d, bo, st, da);
                    model(3, ra, rb, rbi, ed, eb);
                    checks++;
                    if (d !== 4'(ed) || bo !== 1'(eb)) begin
                        errors++;
                        $display("FAIL sweep_w3 %0d-%0d-%0d got %0d/%b want %0d/%0d",
                                 ra, rb, rbi, d, bo, ed, eb);
                    end
                    checks++;
                    if (lat !== 3) begin
                        errors++;
                        $display("FAIL sweep_lat %0d-%0d-%0d got %0d want 3",
                                 ra, rb, rbi, lat);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_ignore_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
